// File: rtl/alu_stream_ctrl_if.sv
// alu_stream_ctrl_if: inbound byte stream and outbound result stream of the ALU front-end
interface alu_stream_ctrl_if #(parameter int N = 8);
    logic [N-1:0] s_data;
    logic         s_valid;
    logic         s_ready;
    logic [N-1:0] m_data;
    logic         m_z;
    logic         m_valid;
    logic         m_ready;
    modport master (output s_data, s_valid, m_ready, input s_ready, m_data, m_z, m_valid);
    modport slave  (input s_data, s_valid, m_ready, output s_ready, m_data, m_z, m_valid);
endinterface

// File: rtl/alu_stream_ctrl.sv
// alu_stream_ctrl: collects A/B/sel byte triples, drives alu_ip, returns C/Z on a valid/ready stream
module alu_stream_ctrl #(
    parameter int N       = 8,
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    alu_stream_ctrl_if.slave   bus,
    output logic [N-1:0]       alu_A,
    output logic [N-1:0]       alu_B,
    output logic [2:0]         alu_sel,
    input  logic [N-1:0]       alu_C,
    input  logic               alu_Z,
    output logic [CNT_W-1:0]   op_count,
    output logic               sel_err
);
    typedef enum logic [2:0] {GET_A, GET_B, GET_SEL, EXEC, SEND} state_t;
    state_t     state, state_n;
    logic [2:0] cnt;
    logic       s_xfer, m_xfer;
    assign s_xfer = bus.s_valid & bus.s_ready;
    assign m_xfer = bus.m_valid & bus.m_ready;
    always_comb begin
        state_n = state;
        case (state)
            GET_A:   state_n = s_xfer ? GET_B : GET_A;
            GET_B:   state_n = s_xfer ? GET_SEL : GET_B;
            GET_SEL: state_n = s_xfer ? EXEC : GET_SEL;
            EXEC:    state_n = (cnt == '0) ? SEND : EXEC;
            SEND:    state_n = m_xfer ? GET_A : SEND;
            default: state_n = GET_A;
        endcase
    end
    // s_ready is a registered decode of the next state, so m_ready never reaches it combinationally
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= GET_A;
            cnt         <= '0;
            alu_A       <= '0;
            alu_B       <= '0;
            alu_sel     <= '0;
            bus.s_ready <= 1'b0;
            bus.m_data  <= '0;
            bus.m_z     <= 1'b0;
            bus.m_valid <= 1'b0;
            op_count    <= '0;
            sel_err     <= 1'b0;
        end else begin
            state       <= state_n;
            bus.s_ready <= (state_n == GET_A) || (state_n == GET_B) || (state_n == GET_SEL);
            if (s_xfer && state == GET_A) alu_A <= bus.s_data;
            if (s_xfer && state == GET_B) alu_B <= bus.s_data;
            if (s_xfer && state == GET_SEL) begin
                alu_sel <= bus.s_data[2:0];
                cnt     <= 3'(ALU_LAT);
                if (|bus.s_data[N-1:3]) sel_err <= 1'b1;
            end
            if (state == EXEC) begin
                if (cnt == '0) begin
                    bus.m_data  <= alu_C;
                    bus.m_z     <= alu_Z;
                    bus.m_valid <= 1'b1;
                end else begin
                    cnt <= cnt - 3'd1;
                end
            end
            if (state == SEND && m_xfer) begin
                bus.m_valid <= 1'b0;
                op_count    <= op_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_stream_ctrl.sv
// tb_alu_stream_ctrl: directed checks of the ALU stream front-end against a registered ALU stub
module tb_alu_stream_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] alu_A, alu_B, alu_C, f;
    logic [2:0] alu_sel;
    logic       alu_Z;
    logic [3:0] op_count;
    logic       sel_err;
    int         checks = 0;
    int         errors = 0;
    int         exp_ops = 0;

    always #5 clk = ~clk;

    alu_stream_ctrl_if #(.N(8)) sif();

    alu_stream_ctrl #(.N(8), .ALU_LAT(1), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .bus(sif),
        .alu_A(alu_A), .alu_B(alu_B), .alu_sel(alu_sel),
        .alu_C(alu_C), .alu_Z(alu_Z),
        .op_count(op_count), .sel_err(sel_err)
    );

    // registered ALU stub, one cycle of latency
    always_comb f = (alu_sel == 3'd0) ? alu_A + alu_B :
                    (alu_sel == 3'd1) ? alu_A - alu_B :
                    (alu_sel == 3'd2) ? alu_A & alu_B : alu_A ^ alu_B;
    always_ff @(posedge clk) begin
        alu_C <= f;
        alu_Z <= (f == 8'd0);
    end

    task automatic put(input logic [7:0] b);
        int n;
        n = 0;
        sif.s_data  = b;
        sif.s_valid = 1'b1;
        while (!sif.s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sif.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL put_timeout: s_ready=%b required 1", sif.s_ready);
        end
        @(negedge clk);
        sif.s_valid = 1'b0;
    endtask

    task automatic wait_valid;
        int n;
        n = 0;
        while (!sif.m_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sif.m_valid !== 1'b1) begin
            errors++;
            $display("FAIL m_valid_timeout: m_valid=%b required 1", sif.m_valid);
        end
    endtask

    task automatic triple(input logic [7:0] a, input logic [7:0] b, input logic [7:0] sel,
                          input logic [7:0] exp_c, input logic exp_z, input logic gap);
        put(a);
        if (gap) @(negedge clk);
        put(b);
        if (gap) @(negedge clk);
        put(sel);
        wait_valid();
        checks++;
        if (sif.m_data !== exp_c) begin
            errors++;
            $display("FAIL m_data: got %h required %h", sif.m_data, exp_c);
        end
        checks++;
        if (sif.m_z !== exp_z) begin
            errors++;
            $display("FAIL m_z: got %b required %b", sif.m_z, exp_z);
        end
        checks++;
        if (alu_A !== a || alu_B !== b || alu_sel !== sel[2:0]) begin
            errors++;
            $display("FAIL operands: got %h %h %h required %h %h %h", alu_A, alu_B, alu_sel, a, b, sel[2:0]);
        end
        if (sif.m_ready) begin
            @(negedge clk);
            exp_ops++;
            checks++;
            if (sif.m_valid !== 1'b0 || op_count !== 4'(exp_ops)) begin
                errors++;
                $display("FAIL complete: m_valid=%b op_count=%0d required 0 %0d", sif.m_valid, op_count, 4'(exp_ops));
            end
        end
    endtask

    task automatic check_cleared(input string tag);
        checks++;
        if (sif.m_valid !== 1'b0 || sif.m_data !== 8'd0 || sif.m_z !== 1'b0 || sif.s_ready !== 1'b0 ||
            op_count !== 4'd0 || sel_err !== 1'b0 || alu_A !== 8'd0 || alu_B !== 8'd0 || alu_sel !== 3'd0) begin
            errors++;
            $display("FAIL %s: m_valid=%b m_data=%h m_z=%b s_ready=%b op_count=%0d sel_err=%b A=%h B=%h sel=%h required all 0",
                     tag, sif.m_valid, sif.m_data, sif.m_z, sif.s_ready, op_count, sel_err, alu_A, alu_B, alu_sel);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;
        exp_ops = 0;
        @(negedge clk);
        checks++;
        if (sif.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: s_ready=%b required 1", sif.s_ready);
        end
    endtask

    task automatic test_basic_add;
        put(8'd5);
        put(8'd3);
        put(8'd0);
        checks++;
        if (sif.m_valid !== 1'b0 || sif.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL exec_cycle1: m_valid=%b s_ready=%b required 0 0", sif.m_valid, sif.s_ready);
        end
        @(negedge clk);
        checks++;
        if (sif.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL exec_cycle2: m_valid=%b required 0", sif.m_valid);
        end
        @(negedge clk);
        checks++;
        if (sif.m_valid !== 1'b1 || sif.m_data !== 8'd8 || sif.m_z !== 1'b0) begin
            errors++;
            $display("FAIL add_result: m_valid=%b m_data=%h m_z=%b required 1 08 0", sif.m_valid, sif.m_data, sif.m_z);
        end
        @(negedge clk);
        exp_ops++;
        checks++;
        if (op_count !== 4'd1 || sif.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_count: op_count=%0d m_valid=%b required 1 0", op_count, sif.m_valid);
        end
    endtask

    task automatic test_zero_wrap;
        triple(8'd7, 8'd7, 8'd1, 8'd0, 1'b1, 1'b0);
        triple(8'd127, 8'd1, 8'd0, 8'h80, 1'b0, 1'b0);
    endtask

    task automatic test_back_pressure;
        sif.m_ready = 1'b0;
        put(8'd20);
        put(8'd10);
        put(8'd1);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sif.s_valid = 1'b1;
            sif.s_data  = 8'hFF;
            checks++;
            if (sif.m_valid !== 1'b1 || sif.m_data !== 8'd10 || sif.s_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d: m_valid=%b m_data=%h s_ready=%b required 1 0a 0", i, sif.m_valid, sif.m_data, sif.s_ready);
            end
        end
        sif.s_valid = 1'b0;
        sif.m_ready = 1'b1;
        @(negedge clk);
        exp_ops++;
        checks++;
        if (op_count !== 4'(exp_ops) || sif.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL release: op_count=%0d m_valid=%b required %0d 0", op_count, sif.m_valid, 4'(exp_ops));
        end
        triple(8'd1, 8'd2, 8'd0, 8'd3, 1'b0, 1'b0);
    endtask

    task automatic test_gapped;
        triple(8'd10, 8'd20, 8'd0, 8'd30, 1'b0, 1'b1);
        triple(8'd50, 8'd8, 8'd1, 8'd42, 1'b0, 1'b1);
        triple(8'd200, 8'd100, 8'd0, 8'd44, 1'b0, 1'b1);
    endtask

    task automatic test_sel_err;
        triple(8'd3, 8'd1, 8'h0A, 8'd1, 1'b0, 1'b0);
        checks++;
        if (sel_err !== 1'b1) begin
            errors++;
            $display("FAIL sel_err_set: sel_err=%b required 1", sel_err);
        end
        triple(8'd4, 8'd4, 8'd1, 8'd0, 1'b1, 1'b0);
        checks++;
        if (sel_err !== 1'b1) begin
            errors++;
            $display("FAIL sel_err_sticky: sel_err=%b required 1", sel_err);
        end
    endtask

    task automatic test_reset_in_send;
        sif.m_ready = 1'b0;
        put(8'd9);
        put(8'd9);
        put(8'd0);
        wait_valid();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_cleared("reset_in_send");
        exp_ops = 0;
        sif.m_ready = 1'b1;
        triple(8'd2, 8'd2, 8'd0, 8'd4, 1'b0, 1'b0);
    endtask

    task automatic test_counter_wrap;
        test_reset();
        for (int i = 0; i < 17; i++) triple(8'(i), 8'd1, 8'd0, 8'(i + 1), 1'b0, 1'b0);
        checks++;
        if (op_count !== 4'd1) begin
            errors++;
            $display("FAIL counter_wrap: op_count=%0d required 1", op_count);
        end
    endtask

    initial begin
        sif.s_data  = 8'd0;
        sif.s_valid = 1'b0;
        sif.m_ready = 1'b1;
        test_reset();
        test_basic_add();
        test_zero_wrap();
        test_back_pressure();
        test_gapped();
        test_sel_err();
        test_reset_in_send();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
